// File: rtl/slot_alloc.sv
// Circular round-robin slot allocator: offers the first free slot below the last
// grant over valid/ready, takes slots back on a release port, and supports drain.
module slot_alloc #(
  parameter  int W  = 32,
  localparam int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          arst_n,
  output logic          alloc_vld_o,
  input  logic          alloc_rdy_i,
  output logic [IW-1:0] alloc_id_o,
  input  logic          free_vld_i,
  input  logic [IW-1:0] free_id_i,
  input  logic          drain_i,
  output logic          drain_done_o,
  output logic [W-1:0]  busy_o,
  output logic [IW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          err_o
);

  localparam logic [IW:0] CNT_ONE = (IW+1)'(1);
  localparam logic [IW:0] CNT_W   = (IW+1)'(W);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e        state_q;
  logic          drain_done_q;
  logic [W-1:0]  busy_q, busy_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   count_q, count_d;
  logic          err_q, err_d;

  logic [IW-1:0] cand;
  logic [IW-1:0] idx;
  logic          full;
  logic          grant;
  logic          free_ok;
  logic          free_bad;

  // Scan ptr-1 down to ptr (with wrap); later iterations are nearer ptr-1 and win.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cand = ptr_q - 1'b1;
    idx  = '0;
    for (int k = W; k >= 1; k--) begin
      idx = ptr_q - IW'(k);
      if (!busy_q[idx]) cand = idx;
    end
  end

  assign full        = (count_q == CNT_W);
  assign alloc_vld_o = arst_n & (state_q == RUN) & ~full;
  assign grant       = alloc_vld_o & alloc_rdy_i;
  assign free_ok     = free_vld_i &  busy_q[free_id_i];
  assign free_bad    = free_vld_i & ~busy_q[free_id_i];

  always_comb begin
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q | free_bad;
    if (grant) begin
      busy_d[cand] = 1'b1;
      ptr_d        = cand;
    end
    // A grant id is always free and a valid release id is always busy, so no overlap.
    if (free_ok) busy_d[free_id_i] = 1'b0;
    case ({grant, free_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= RUN;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        RUN:   if (drain_i) state_q <= DRAIN;
        DRAIN: if (count_q == '0) begin
          state_q      <= RUN;
          drain_done_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign alloc_id_o   = cand;
  assign drain_done_o = drain_done_q;
  assign busy_o       = busy_q;
  assign count_o      = count_q;
  assign full_o       = full;
  assign empty_o      = (count_q == '0);
  assign err_o        = err_q;

endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc (W=32): downward grant walk, full/refill, circular
// search, simultaneous grant+release, sticky error, drain, and mid-run reset.
module tb_slot_alloc;

  localparam int W  = 32;
  localparam int IW = $clog2(W);

  logic          clk;
  logic          arst_n;
  logic          alloc_vld;
  logic          alloc_rdy;
  logic [IW-1:0] alloc_id;
  logic          free_vld;
  logic [IW-1:0] free_id;
  logic          drain;
  logic          drain_done;
  logic [W-1:0]  busy;
  logic [IW:0]   count;
  logic          full;
  logic          empty;
  logic          err;

  int checks = 0;
  int errors = 0;

  slot_alloc #(.W(W)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .alloc_vld_o  (alloc_vld),
    .alloc_rdy_i  (alloc_rdy),
    .alloc_id_o   (alloc_id),
    .free_vld_i   (free_vld),
    .free_id_i    (free_id),
    .drain_i      (drain),
    .drain_done_o (drain_done),
    .busy_o       (busy),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic free_slot(input int id);
    free_vld = 1'b1;
    free_id  = IW'(id);
    step();
    free_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] keep;
    int seq[$];

    arst_n = 1'b0; alloc_rdy = 1'b0; free_vld = 1'b0; free_id = '0; drain = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vld",   alloc_vld,  0);
    check("rst_id",    alloc_id,   31);
    check("rst_empty", empty,      1);
    check("rst_full",  full,       0);
    check("rst_done",  drain_done, 0);
    check("rst_count", count,      0);
    check("rst_busy",  busy,       0);
    check("rst_err",   err,        0);

    // Downward walk 31..0 with ready held high
    step();
    arst_n = 1'b1;
    alloc_rdy = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("walk_vld", alloc_vld, 1);
      check("walk_id",  alloc_id,  32'(31 - i));
      step();
    end
    alloc_rdy = 1'b0;
    @(negedge clk);
    check("full_flag",  full,      1);
    check("full_vld",   alloc_vld, 0);
    check("full_count", count,     32);
    check("full_busy",  busy,      32'hFFFF_FFFF);

    // Release slot 5 while full: offered only from the next cycle
    step();
    free_vld = 1'b1; free_id = 5'd5;
    @(negedge clk);
    check("full_free_vld", alloc_vld, 0);
    step();
    free_vld = 1'b0;
    @(negedge clk);
    check("refill_vld",   alloc_vld, 1);
    check("refill_id",    alloc_id,  5);
    check("refill_count", count,     31);
    alloc_rdy = 1'b1;
    step();
    alloc_rdy = 1'b0;
    @(negedge clk);
    check("refull", full, 1);

    // Move ptr to 8, then shape busy = 0x137
    free_slot(8);
    @(negedge clk);
    check("ptr8_id", alloc_id, 8);
    alloc_rdy = 1'b1;
    step();
    alloc_rdy = 1'b0;
    keep = 32'h0000_0137;
    for (int i = 0; i < W; i++)
      if (!keep[i]) free_slot(i);
    @(negedge clk);
    check("pat_busy",  busy,     32'h0000_0137);
    check("pat_count", count,    6);
    check("pat_id",    alloc_id, 7);
    alloc_rdy = 1'b1;
    step();
    alloc_rdy = 1'b0;
    @(negedge clk);
    check("pat_next_id", alloc_id, 6);

    // Grants 6,3,31..21 then grant 20 alongside release of 3
    seq = '{6, 3};
    for (int k = 31; k >= 21; k--) seq.push_back(k);
    alloc_rdy = 1'b1;
    foreach (seq[j]) begin
      check("wrap_id", alloc_id, 32'(seq[j]));
      step();
      @(negedge clk);
    end
    free_vld = 1'b1; free_id = 5'd3;
    check("sim_id",        alloc_id, 20);
    check("sim_count_pre", count,    20);
    step();
    free_vld = 1'b0;
    alloc_rdy = 1'b0;
    @(negedge clk);
    check("sim_count", count,    20);
    check("sim_busy",  busy,     32'hFFF0_01F7);
    check("sim_id2",   alloc_id, 19);

    // Release of an idle slot: sticky error, no state change
    free_vld = 1'b1; free_id = 5'd9;
    step();
    free_vld = 1'b0;
    @(negedge clk);
    check("err_set",   err,   1);
    check("err_count", count, 20);
    check("err_busy",  busy,  32'hFFF0_01F7);
    alloc_rdy = 1'b1;
    check("err_traffic_id", alloc_id, 19);
    step();
    alloc_rdy = 1'b0;
    @(negedge clk);
    check("err_sticky",      err,   1);
    check("err_count_after", count, 21);

    // Leave slots 0,1,2 busy, ptr stays at 19, then drain
    for (int i = 4; i <= 8; i++) free_slot(i);
    for (int i = 19; i <= 31; i++) free_slot(i);
    @(negedge clk);
    check("pre_drain_count", count,    3);
    check("pre_drain_busy",  busy,     32'h0000_0007);
    check("pre_drain_id",    alloc_id, 18);
    drain = 1'b1;
    check("drain_entry_vld", alloc_vld, 1);
    step();
    drain = 1'b0;
    alloc_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      free_vld = (c % 2 == 0);
      free_id  = IW'(c / 2);
      @(negedge clk);
      check("drain_vld",  alloc_vld,  0);
      check("drain_done_early", drain_done, 0);
      step();
      free_vld = 1'b0;
    end
    @(negedge clk);
    check("drain_zero_vld",   alloc_vld,  0);
    check("drain_zero_done",  drain_done, 0);
    check("drain_zero_count", count,      0);
    step();
    @(negedge clk);
    check("drain_done_pulse", drain_done, 1);
    check("drain_resume_vld", alloc_vld,  1);
    check("drain_resume_id",  alloc_id,   18);
    step();
    alloc_rdy = 1'b0;
    @(negedge clk);
    check("drain_done_clear", drain_done, 0);
    check("post_drain_count", count,      1);
    check("post_drain_busy",  busy,       32'h0004_0000);
    check("post_drain_err",   err,        1);

    // Asynchronous reset mid-run
    arst_n = 1'b0;
    #1;
    check("mid_rst_vld",   alloc_vld, 0);
    check("mid_rst_busy",  busy,      0);
    check("mid_rst_count", count,     0);
    check("mid_rst_err",   err,       0);
    check("mid_rst_id",    alloc_id,  31);
    check("mid_rst_empty", empty,     1);
    step();
    arst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slot_alloc.md
Name: slot_alloc

Overview:
- Circular round-robin slot/tag allocator managing a pool of W slots, tracked by a registered busy vector.
- Each cycle it searches circularly for a free slot, starting just below the last-granted position, and offers that slot to one requester over a valid/ready handshake.
- Freed slots return through a separate release port; a drain mode blocks new grants until the pool is empty.
- Sits in front of any W-entry resource (buffer, tag table) and reuses the circular leftmost-zero search datapath.

Parameters:
- W, 32, number of slots; power of two, W >= 4.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- alloc_vld_o  out  1  a free slot is offered this cycle
- alloc_rdy_i  in  1  requester accepts the offered slot
- alloc_id_o  out  $clog2(W)  offered slot index; valid only while alloc_vld_o=1
- free_vld_i  in  1  release request
- free_id_i  in  $clog2(W)  slot to release
- drain_i  in  1  request drain: block grants until all slots are free
- drain_done_o  out  1  single-cycle pulse when a drain completes
- busy_o  out  W  registered busy vector
- count_o  out  $clog2(W)+1  number of busy slots
- full_o  out  1  count_o == W
- empty_o  out  1  count_o == 0
- err_o  out  1  sticky flag: a release was issued for a slot that is not busy

Behaviour:
- Reset (async assert, sync deassert into logic):
  - busy=0, ptr=0, count=0, state=RUN, err=0.
  - Outputs under reset: alloc_vld_o=0 (forced low while arst_n=0), alloc_id_o=W-1, empty_o=1, full_o=0, drain_done_o=0.
- Search:
  - Candidate = first 0 in busy, scanning ptr-1, ptr-2, ... with wrap, ending at ptr itself.
  - Purely combinational from registered state; zero-cycle offer latency.
- alloc_vld_o = (state==RUN) & ~full.
- alloc_id_o is stable while alloc_vld_o=1 and alloc_rdy_i=0; it changes only on a grant or when a free changes the search result.
- Grant (alloc_vld_o & alloc_rdy_i):
  - At the next edge: busy[alloc_id_o]<=1, ptr<=alloc_id_o, count+1.
  - Successive grants therefore walk downward: W-1, W-2, ..., wrapping.
- Release (free_vld_i):
  - If busy[free_id_i]=1: at the next edge, busy bit cleared and count-1.
  - If busy[free_id_i]=0: no state change; err_o<=1 (sticky until reset).
- Simultaneous grant and release in one cycle:
  - Both apply; count is net unchanged.
  - A freed slot is not offerable in the same cycle. No bypass: it becomes visible one cycle later.
  - The grant id can never equal a valid release id, because the grant id is free and the release id is busy.
- Full: alloc_vld_o=0. A release while full makes alloc_vld_o=1 on the next cycle, offering the freed slot if it is the only one free.
- State machine:
  - RUN -> DRAIN when drain_i=1.
    - If a grant handshakes in the same cycle, the grant completes.
    - alloc_vld_o is 0 from the next cycle onward.
  - DRAIN -> RUN when count==0 (evaluated on registered count).
    - drain_done_o=1 for exactly that cycle.
    - drain_i is ignored while in DRAIN.
    - If already empty on entry, DRAIN lasts one cycle, then pulses.
  - ptr is preserved across a drain.
- count_o width $clog2(W)+1, so count==W is representable; it must equal popcount(busy_o) every cycle.
- Reset mid-operation: all state clears immediately; outstanding slots are forgotten; err_o clears.

Test Plan:
- Reset, alloc_rdy_i=1 held, W=32 -> grants 31,30,...,0 on consecutive cycles; after 32 grants full_o=1, alloc_vld_o=0, count_o=32.
- From full: free_id_i=5 for 1 cycle -> next cycle alloc_vld_o=1, alloc_id_o=5; grant -> full_o=1 again.
- busy=0x0000_0137 set via grants/frees, ptr=8 -> alloc_id_o=7; grant -> ptr=7, next offer 6 (bit 6 free).
- Simultaneous grant id 20 and release id 3 -> count unchanged; slot 3 is not offered in the same cycle and is offerable from the next cycle.
- Release id 9 while busy[9]=0 -> busy/count unchanged, err_o=1 and stays 1 through later traffic until arst_n low.
- drain_i with count=3, then release the 3 slots over 5 cycles -> alloc_vld_o=0 throughout; drain_done_o pulses 1 cycle after count reaches 0; next grant continues from the saved ptr.
